enemy_ai_ctrl: RTL and testbench
================================

// Module: enemy_ai_ctrl
// PURPOSE
//  Tick-driven behaviour controller for the enemy character. It replaces free-running random stimulus with a sequenced FSM.
//  It reads player/enemy positions and bullet status from the game datapath.
//  It drives the enemy's right/left/jump/squat/attack/defend command lines and the bad-bullet attack request.
//  Sits between the game-state controller (enable) and the enemy and bad-bullet datapaths.
// PARAMETERS
//  NEAR_DIST    11'd120  |dx| below this -> RETREAT
//  FAR_DIST     11'd320  |dx| above this -> APPROACH
//  THREAT_DIST  11'd96   incoming good bullet |dx| below this -> EVADE
//  THREAT_DY    10'd32   incoming good bullet |dy| below this -> EVADE
//  FIRE_HOLD    4        ticks o_attack held per volley
//  COOL_TICKS   16       ticks idle after a volley
//  DEF_MAX      4'd8     defend budget ceiling (ticks)
// PORTS
//  clk              in   1   system clock
//  rst              in   1   synchronous reset, active-high
//  i_enable         in   1   game in PLAY state
//  i_tick           in   1   one-cycle frame-rate strobe
//  i_player_x       in   11  signed player x
//  i_player_y       in   10  signed player y
//  i_enemy_x        in   11  signed enemy x
//  i_enemy_y        in   10  signed enemy y
//  i_enemy_hp       in   2   enemy hit points
//  i_goodbullet_x   in   11  signed player-bullet x
//  i_goodbullet_y   in   10  signed player-bullet y
//  i_goodbullet_isE in   1   player bullet exists
//  i_badbullet_isE  in   1   enemy bullet exists (in flight)
//  o_right/o_left   out  1   move commands (never both 1)
//  o_jump/o_squat   out  1   jump / squat commands
//  o_attack         out  1   bad-bullet fire request
//  o_defend         out  1   enemy shield request
//  o_ai_state       out  3   current FSM state (debug)
// BEHAVIOUR
//  - Clock and reset: single clock. Reset is synchronous and active-high.
//  - Reset values:
//    - all command outputs 0;
//    - state IDLE (3'd0); counters 0;
//    - defend budget = DEF_MAX.
//  - Registered outputs: all outputs are registered. Commands update only on the cycle after i_tick=1 and are held between ticks.
//  - Distance arithmetic:
//    - differences use 12-bit signed subtraction;
//    - |dx| saturates at 11'h7FF and |dy| saturates at 10'h3FF;
//    - comparisons are strict (<, >).
//  - States (encoding): IDLE 0, APPROACH 1, RETREAT 2, FIRE 3, COOL 4, EVADE 5.
//  - Threat detection: threat = i_goodbullet_isE && |gbx-ex|<THREAT_DIST && |gby-ey|<THREAT_DY. Threat preempts every state on the next tick -> EVADE.
//  - IDLE: each tick, |dx|>FAR_DIST -> APPROACH; |dx|<NEAR_DIST -> RETREAT; otherwise -> FIRE.
//  - APPROACH: step toward the player. o_right=1 if px>ex, otherwise o_left=1. Re-evaluate each tick as in IDLE.
//  - RETREAT: step away from the player. Re-evaluate as in IDLE.
//  - FIRE: o_attack=1 only while !i_badbullet_isE. The hold counter advances only on ticks where attack is asserted. After FIRE_HOLD counted ticks -> COOL.
//  - COOL: all commands 0 for COOL_TICKS ticks, then -> IDLE. When i_enemy_hp==1 the period is COOL_TICKS/2.
//  - EVADE:
//    - if budget>0: o_defend=1 and budget-1 per tick;
//    - if budget==0: o_jump=1 for one tick;
//    - when the threat clears -> IDLE.
//  - Budget refill: +1 per 8 consecutive non-defend ticks, saturating at DEF_MAX.
//  - Left/right exclusion: o_left and o_right are mutually exclusive in every state.
//  - o_squat is asserted only in EVADE when budget==0 and gby>ey (low bullet); in that case o_squat replaces o_jump.
//  - i_enable low:
//    - next cycle, outputs 0, state IDLE, counters cleared;
//    - budget reloads to DEF_MAX.
//    - Applies mid-volley too; a pending FIRE is not resumed.
//  - Simultaneous rst and i_tick: rst wins.
//  - i_tick while disabled: i_tick is ignored while i_enable=0.
// CONFIGURATION
//  - ENEMY_AI_LFSR_EN defined:
//    - 8-bit LFSR x^8+x^6+x^5+x^4+1, reset seed 8'hA5, advanced on each enabled tick;
//    - in APPROACH, o_jump=1 on ticks where lfsr[1:0]==2'b11;
//    - COOL length is extended by lfsr[2:0] ticks (latched on COOL entry).
//  - ENEMY_AI_LFSR_EN undefined: fully deterministic; no jumps in APPROACH; fixed COOL length.
// TESTING
//  T1 Reset: rst=1 for 2 cycles -> all outputs 0, o_ai_state=0; the cycle after rst falls the outputs are still 0 with no tick.
//  T2 Approach/retreat:
//     - px=600, ex=100, tick -> o_ai_state=1, o_right=1, o_left=0;
//     - px=150, ex=100, tick -> state 2, o_left=1.
//  T3 Fire:
//     - px=300, ex=100, badbullet_isE=0 -> o_attack=1 for 4 ticks, then state 4 for 16 ticks, then 0;
//     - badbullet_isE=1 during FIRE stalls the count.
//  T4 Evade:
//     - gb at (ex+50, ey), isE=1 -> state 5, o_defend=1 for 8 ticks;
//     - 9th tick -> o_jump=1 and o_defend=0;
//     - with gby=ey+20 -> o_squat=1 instead.
//  T5 Abort: i_enable=0 during FIRE tick 2 -> next cycle all outputs 0, state 0; re-enable -> budget=8.
//  T6 Low HP and LFSR: hp=1 -> COOL lasts 8 ticks; with ENEMY_AI_LFSR_EN the first COOL lasts 8+(lfsr[2:0] from the A5 sequence) ticks.

Source files
------------

// File: rtl/enemy_ai_ctrl_if.sv
// Signal bundle between the enemy AI controller and the game datapath.
// The controller uses the slave modport; the game side uses master.
interface enemy_ai_ctrl_if;
  logic        i_enable;
  logic        i_tick;
  logic [10:0] i_player_x;
  logic [9:0]  i_player_y;
  logic [10:0] i_enemy_x;
  logic [9:0]  i_enemy_y;
  logic [1:0]  i_enemy_hp;
  logic [10:0] i_goodbullet_x;
  logic [9:0]  i_goodbullet_y;
  logic        i_goodbullet_isE;
  logic        i_badbullet_isE;
  logic        o_right;
  logic        o_left;
  logic        o_jump;
  logic        o_squat;
  logic        o_attack;
  logic        o_defend;
  logic [2:0]  o_ai_state;

  modport master (
    output i_enable, i_tick, i_player_x, i_player_y, i_enemy_x, i_enemy_y,
           i_enemy_hp, i_goodbullet_x, i_goodbullet_y, i_goodbullet_isE,
           i_badbullet_isE,
    input  o_right, o_left, o_jump, o_squat, o_attack, o_defend, o_ai_state
  );

  modport slave (
    input  i_enable, i_tick, i_player_x, i_player_y, i_enemy_x, i_enemy_y,
           i_enemy_hp, i_goodbullet_x, i_goodbullet_y, i_goodbullet_isE,
           i_badbullet_isE,
    output o_right, o_left, o_jump, o_squat, o_attack, o_defend, o_ai_state
  );
endinterface

// File: rtl/enemy_ai_ctrl.sv
// Tick-driven enemy behaviour FSM: approach/retreat/fire/cool/evade with a defend budget.
// Optional ENEMY_AI_LFSR_EN adds random jumps in APPROACH and a random COOL extension.
//
//  state    | meaning
//  IDLE     | waiting for the next tick to pick a behaviour from distance
//  APPROACH | player far away, step toward the player
//  RETREAT  | player too close, step away from the player
//  FIRE     | mid range, fire volley until FIRE_HOLD attack ticks are counted
//  COOL     | idle after a volley (shorter at low hp)
//  EVADE    | incoming player bullet, shield while budget lasts, then jump/squat
module enemy_ai_ctrl #(
  parameter logic [10:0] NEAR_DIST   = 11'd120,
  parameter logic [10:0] FAR_DIST    = 11'd320,
  parameter logic [10:0] THREAT_DIST = 11'd96,
  parameter logic [9:0]  THREAT_DY   = 10'd32,
  parameter int unsigned FIRE_HOLD   = 4,
  parameter int unsigned COOL_TICKS  = 16,
  parameter logic [3:0]  DEF_MAX     = 4'd8
) (
  input logic            clk,
  input logic            rst,
  enemy_ai_ctrl_if.slave ai
);

  localparam logic [3:0] HOLD_INIT = 4'(FIRE_HOLD);
  localparam logic [4:0] COOL_FULL = 5'(COOL_TICKS);
  localparam logic [4:0] COOL_HALF = 5'(COOL_TICKS / 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_APPROACH = 3'd1,
    S_RETREAT  = 3'd2,
    S_FIRE     = 3'd3,
    S_COOL     = 3'd4,
    S_EVADE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        right_q, right_d, left_q, left_d, jump_q, jump_d;
  logic        squat_q, squat_d, attack_q, attack_d, defend_q, defend_d;
  logic [3:0]  hold_q, hold_d;
  logic [4:0]  cool_q, cool_d;
  logic [3:0]  budget_q, budget_d;
  logic [2:0]  refill_q, refill_d;
`ifdef ENEMY_AI_LFSR_EN
  logic [7:0]  lfsr_q, lfsr_d;
`endif

  logic [10:0] dx_abs, gdx_abs;
  logic [9:0]  gdy_abs;
  logic        threat, player_right, bullet_low;
  state_t      range_st;
  logic [3:0]  hold_cur;
  logic [4:0]  cool_len;

  // Magnitudes come from 12-bit signed differences, saturated to the field width.
  function automatic logic [10:0] abs_dx(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] diff, mag;
    diff = {a[10], a} - {b[10], b};
    mag  = diff[11] ? (~diff + 12'd1) : diff;
    return mag[11] ? 11'h7FF : mag[10:0];
  endfunction

  function automatic logic [9:0] abs_dy(input logic [9:0] a, input logic [9:0] b);
    logic [11:0] diff, mag;
    diff = {{2{a[9]}}, a} - {{2{b[9]}}, b};
    mag  = diff[11] ? (~diff + 12'd1) : diff;
    return (mag > 12'h3FF) ? 10'h3FF : mag[9:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    right_d  = right_q;
    left_d   = left_q;
    jump_d   = jump_q;
    squat_d  = squat_q;
    attack_d = attack_q;
    defend_d = defend_q;
    hold_d   = hold_q;
    cool_d   = cool_q;
    budget_d = budget_q;
    refill_d = refill_q;
`ifdef ENEMY_AI_LFSR_EN
    lfsr_d   = lfsr_q;
`endif

    dx_abs       = abs_dx(ai.i_player_x, ai.i_enemy_x);
    gdx_abs      = abs_dx(ai.i_goodbullet_x, ai.i_enemy_x);
    gdy_abs      = abs_dy(ai.i_goodbullet_y, ai.i_enemy_y);
    threat       = ai.i_goodbullet_isE && (gdx_abs < THREAT_DIST) && (gdy_abs < THREAT_DY);
    player_right = $signed(ai.i_player_x) > $signed(ai.i_enemy_x);
    bullet_low   = $signed(ai.i_goodbullet_y) > $signed(ai.i_enemy_y);

    if (dx_abs > FAR_DIST)       range_st = S_APPROACH;
    else if (dx_abs < NEAR_DIST) range_st = S_RETREAT;
    else                         range_st = S_FIRE;

    hold_cur = (state_q == S_FIRE) ? hold_q : HOLD_INIT;
    cool_len = (ai.i_enemy_hp == 2'd1) ? COOL_HALF : COOL_FULL;
`ifdef ENEMY_AI_LFSR_EN
    cool_len = cool_len + {2'b00, lfsr_q[2:0]};
`endif

    if (!ai.i_enable) begin
      state_d  = S_IDLE;
      right_d  = 1'b0;
      left_d   = 1'b0;
      jump_d   = 1'b0;
      squat_d  = 1'b0;
      attack_d = 1'b0;
      defend_d = 1'b0;
      hold_d   = '0;
      cool_d   = '0;
      refill_d = '0;
      budget_d = DEF_MAX;
    end else if (ai.i_tick) begin
`ifdef ENEMY_AI_LFSR_EN
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
      case (state_q)
        S_IDLE, S_APPROACH, S_RETREAT: state_d = range_st;
        S_FIRE:  state_d = (hold_q == 4'd0) ? S_COOL : S_FIRE;
        S_COOL:  state_d = (cool_q == 5'd0) ? S_IDLE : S_COOL;
        default: state_d = S_IDLE;
      endcase
      if (threat) state_d = S_EVADE;

      // Commands reflect the action of the state being entered on this tick.
      right_d  = 1'b0;
      left_d   = 1'b0;
      jump_d   = 1'b0;
      squat_d  = 1'b0;
      attack_d = 1'b0;
      defend_d = 1'b0;
      hold_d   = '0;
      cool_d   = '0;
      case (state_d)
        S_APPROACH: begin
          right_d = player_right;
          left_d  = !player_right;
`ifdef ENEMY_AI_LFSR_EN
          jump_d  = &lfsr_q[1:0];
`endif
        end
        S_RETREAT: begin
          right_d = !player_right;
          left_d  = player_right;
        end
        S_FIRE: begin
          attack_d = !ai.i_badbullet_isE;
          hold_d   = ai.i_badbullet_isE ? hold_cur : hold_cur - 4'd1;
        end
        S_COOL: cool_d = (state_q == S_COOL) ? cool_q - 5'd1 : cool_len - 5'd1;
        S_EVADE: begin
          if (budget_q != 4'd0) begin
            defend_d = 1'b1;
            budget_d = budget_q - 4'd1;
          end else if (bullet_low) begin
            squat_d = 1'b1;
          end else begin
            jump_d = 1'b1;
          end
        end
        default: ;
      endcase

      if (defend_d) begin
        refill_d = '0;
      end else if (refill_q == 3'd7) begin
        refill_d = '0;
        if (budget_q < DEF_MAX) budget_d = budget_q + 4'd1;
      end else begin
        refill_d = refill_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      right_q  <= 1'b0;
      left_q   <= 1'b0;
      jump_q   <= 1'b0;
      squat_q  <= 1'b0;
      attack_q <= 1'b0;
      defend_q <= 1'b0;
      hold_q   <= '0;
      cool_q   <= '0;
      budget_q <= DEF_MAX;
      refill_q <= '0;
`ifdef ENEMY_AI_LFSR_EN
      lfsr_q   <= 8'hA5;
`endif
    end else begin
      state_q  <= state_d;
      right_q  <= right_d;
      left_q   <= left_d;
      jump_q   <= jump_d;
      squat_q  <= squat_d;
      attack_q <= attack_d;
      defend_q <= defend_d;
      hold_q   <= hold_d;
      cool_q   <= cool_d;
      budget_q <= budget_d;
      refill_q <= refill_d;
`ifdef ENEMY_AI_LFSR_EN
      lfsr_q   <= lfsr_d;
`endif
    end
  end

  assign ai.o_right    = right_q;
  assign ai.o_left     = left_q;
  assign ai.o_jump     = jump_q;
  assign ai.o_squat    = squat_q;
  assign ai.o_attack   = attack_q;
  assign ai.o_defend   = defend_q;
  assign ai.o_ai_state = state_q;

endmodule

// File: tb/tb_enemy_ai_ctrl.sv
// Scoreboard bench for enemy_ai_ctrl: expected state/commands are queued per tick
// and compared against the registered outputs one cycle later.
module tb_enemy_ai_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  enemy_ai_ctrl_if aif();
  enemy_ai_ctrl dut (.clk(clk), .rst(rst), .ai(aif.slave));

  localparam logic [5:0] C_NONE   = 6'b000000;
  localparam logic [5:0] C_RIGHT  = 6'b100000;
  localparam logic [5:0] C_LEFT   = 6'b010000;
  localparam logic [5:0] C_JUMP   = 6'b001000;
  localparam logic [5:0] C_SQUAT  = 6'b000100;
  localparam logic [5:0] C_ATTACK = 6'b000010;
  localparam logic [5:0] C_DEFEND = 6'b000001;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [5:0] cmd;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
`ifdef ENEMY_AI_LFSR_EN
  logic [7:0] lfsr_m = 8'hA5;
`endif

  function automatic logic [8:0] observed();
    return {aif.o_ai_state, aif.o_right, aif.o_left, aif.o_jump,
            aif.o_squat, aif.o_attack, aif.o_defend};
  endfunction

  function automatic logic [5:0] appr_jump();
`ifdef ENEMY_AI_LFSR_EN
    return (lfsr_m[1:0] == 2'b11) ? C_JUMP : C_NONE;
`else
    return C_NONE;
`endif
  endfunction

  function automatic int lfsr_ext();
`ifdef ENEMY_AI_LFSR_EN
    return int'(lfsr_m[2:0]);
`else
    return 0;
`endif
  endfunction

  // One-cycle tick pulse; returns at the negedge after the capturing posedge.
  task automatic step();
    @(negedge clk);
    aif.i_tick = 1'b1;
`ifdef ENEMY_AI_LFSR_EN
    if (aif.i_enable) lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
    @(negedge clk);
    aif.i_tick = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sb.push_back(exp_t'{"reset", 3'd0, C_NONE});
    e = sb.pop_front(); n_total++;
    if (observed() !== {e.st, e.cmd}) $display("FAIL %s: got %b want %b", e.name, observed(), {e.st, e.cmd});
    else n_pass++;
    aif.i_player_x = 11'd600; aif.i_enemy_x = 11'd100;
    aif.i_tick = 1'b1;
    sb.push_back(exp_t'{"rst_beats_tick", 3'd0, C_NONE});
    @(negedge clk);
    aif.i_tick = 1'b0;
    e = sb.pop_front(); n_total++;
    if (observed() !== {e.st, e.cmd}) $display("FAIL %s: got %b want %b", e.name, observed(), {e.st, e.cmd});
    else n_pass++;
    rst = 1'b0;
    sb.push_back(exp_t'{"post_reset_no_tick", 3'd0, C_NONE});
    @(negedge clk);
    e = sb.pop_front(); n_total++;
    if (observed() !== {e.st, e.cmd}) $display("FAIL %s: got %b want %b", e.name, observed(), {e.st, e.cmd});
    else n_pass++;
  endtask

  task automatic test_move();
    exp_t e;
    int         px[4] = '{600, 150, 50, -1000};
    int         ex[4] = '{100, 100, 100, 1000};
    logic [2:0] st[4] = '{3'd1, 3'd2, 3'd2, 3'd1};
    logic [5:0] cm[4] = '{C_RIGHT, C_LEFT, C_RIGHT, C_LEFT};
    for (int i = 0; i < 4; i++) begin
      aif.i_player_x = 11'(px[i]);
      aif.i_enemy_x  = 11'(ex[i]);
      sb.push_back(exp_t'{"move", st[i], cm[i] | ((st[i] == 3'd1) ? appr_jump() : C_NONE)});
      step();
      e = sb.pop_front(); n_total++;
      if (observed() !== {e.st, e.cmd}) $display("FAIL %s[%0d]: got %b want %b", e.name, i, observed(), {e.st, e.cmd});
      else n_pass++;
    end
  endtask

  task automatic test_fire();
    exp_t e;
    int   clen;
    aif.i_enable = 1'b0;
    sb.push_back(exp_t'{"disable_clear", 3'd0, C_NONE});
    @(negedge clk);
    aif.i_enable = 1'b1;
    e = sb.pop_front(); n_total++;
    if (observed() !== {e.st, e.cmd}) $display("FAIL %s: got %b want %b", e.name, observed(), {e.st, e.cmd});
    else n_pass++;
    // |dx| exactly FAR_DIST is not "far", so the enemy fires.
    aif.i_player_x = 11'd420; aif.i_enemy_x = 11'd100; aif.i_enemy_hp = 2'd3;
    for (int t = 0; t < 5; t++) begin
      aif.i_badbullet_isE = (t == 1);
      sb.push_back(exp_t'{"fire", 3'd3, (t == 1) ? C_NONE : C_ATTACK});
      step();
      e = sb.pop_front(); n_total++;
      if (observed() !== {e.st, e.cmd}) $display("FAIL %s[%0d]: got %b want %b", e.name, t, observed(), {e.st, e.cmd});
      else n_pass++;
      if (t == 0) begin
        repeat (3) @(negedge clk);
        n_total++;
        if (observed() !== {3'd3, C_ATTACK}) $display("FAIL held_between_ticks: got %b want %b", observed(), {3'd3, C_ATTACK});
        else n_pass++;
      end
    end
    aif.i_badbullet_isE = 1'b0;
    clen = 16 + lfsr_ext();
    for (int t = 0; t <= clen; t++) begin
      sb.push_back(exp_t'{"cool", (t == clen) ? 3'd0 : 3'd4, C_NONE});
      step();
      e = sb.pop_front(); n_total++;
      if (observed() !== {e.st, e.cmd}) $display("FAIL %s[%0d]: got %b want %b", e.name, t, observed(), {e.st, e.cmd});
      else n_pass++;
    end
  endtask

  task automatic test_evade();
    exp_t e;
    int   gx[5] = '{150, 196, 150, 195, 150};
    int   gy[5] = '{200, 200, 232, 231, 200};
    logic ge[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] st[5] = '{3'd0, 3'd1, 3'd1, 3'd5, 3'd0};
    logic [5:0] cm[5] = '{C_NONE, C_RIGHT, C_RIGHT, C_SQUAT, C_NONE};
    aif.i_enemy_x = 11'd100; aif.i_enemy_y = 10'd200;
    aif.i_goodbullet_x = 11'd150; aif.i_goodbullet_y = 10'd200; aif.i_goodbullet_isE = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (t == 9) aif.i_goodbullet_y = 10'd220;
      sb.push_back(exp_t'{"evade", 3'd5, (t < 8) ? C_DEFEND : ((t == 8) ? C_JUMP : C_SQUAT)});
      step();
      e = sb.pop_front(); n_total++;
      if (observed() !== {e.st, e.cmd}) $display("FAIL %s[%0d]: got %b want %b", e.name, t, observed(), {e.st, e.cmd});
      else n_pass++;
    end
    // Threat clears, then threat-window edges (dx=96, dy=32 do not count), then a near-edge hit.
    aif.i_player_x = 11'd600;
    for (int i = 0; i < 4; i++) begin
      aif.i_goodbullet_x = 11'(gx[i]); aif.i_goodbullet_y = 10'(gy[i]); aif.i_goodbullet_isE = ge[i];
      sb.push_back(exp_t'{"evade_edge", st[i], cm[i] | ((st[i] == 3'd1) ? appr_jump() : C_NONE)});
      step();
      e = sb.pop_front(); n_total++;
      if (observed() !== {e.st, e.cmd}) $display("FAIL %s[%0d]: got %b want %b", e.name, i, observed(), {e.st, e.cmd});
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    exp_t e;
    aif.i_goodbullet_isE = 1'b0;
    aif.i_player_x = 11'd420;
    for (int t = 0; t < 3; t++) begin
      sb.push_back(exp_t'{"pre_abort", (t == 0) ? 3'd0 : 3'd3, (t == 0) ? C_NONE : C_ATTACK});
      step();
      e = sb.pop_front(); n_total++;
      if (observed() !== {e.st, e.cmd}) $display("FAIL %s[%0d]: got %b want %b", e.name, t, observed(), {e.st, e.cmd});
      else n_pass++;
    end
    aif.i_enable = 1'b0;
    sb.push_back(exp_t'{"abort", 3'd0, C_NONE});
    @(negedge clk);
    e = sb.pop_front(); n_total++;
    if (observed() !== {e.st, e.cmd}) $display("FAIL %s: got %b want %b", e.name, observed(), {e.st, e.cmd});
    else n_pass++;
    sb.push_back(exp_t'{"tick_disabled", 3'd0, C_NONE});
    step();
    e = sb.pop_front(); n_total++;
    if (observed() !== {e.st, e.cmd}) $display("FAIL %s: got %b want %b", e.name, observed(), {e.st, e.cmd});
    else n_pass++;
    // Budget was drained earlier; a re-enable must restore the full 8 shield ticks.
    aif.i_enable = 1'b1;
    aif.i_goodbullet_x = 11'd150; aif.i_goodbullet_y = 10'd200; aif.i_goodbullet_isE = 1'b1;
    for (int t = 0; t < 9; t++) begin
      sb.push_back(exp_t'{"budget_reload", 3'd5, (t < 8) ? C_DEFEND : C_JUMP});
      step();
      e = sb.pop_front(); n_total++;
      if (observed() !== {e.st, e.cmd}) $display("FAIL %s[%0d]: got %b want %b", e.name, t, observed(), {e.st, e.cmd});
      else n_pass++;
    end
  endtask

  task automatic test_low_hp();
    exp_t e;
    int   clen;
    aif.i_goodbullet_isE = 1'b0;
    aif.i_enable = 1'b0;
    @(negedge clk);
    aif.i_enable = 1'b1;
    aif.i_enemy_hp = 2'd1;
    aif.i_player_x = 11'd420; aif.i_enemy_x = 11'd100;
    for (int t = 0; t < 4; t++) begin
      sb.push_back(exp_t'{"lowhp_fire", 3'd3, C_ATTACK});
      step();
      e = sb.pop_front(); n_total++;
      if (observed() !== {e.st, e.cmd}) $display("FAIL %s[%0d]: got %b want %b", e.name, t, observed(), {e.st, e.cmd});
      else n_pass++;
    end
    clen = 8 + lfsr_ext();
    for (int t = 0; t <= clen; t++) begin
      sb.push_back(exp_t'{"lowhp_cool", (t == clen) ? 3'd0 : 3'd4, C_NONE});
      step();
      e = sb.pop_front(); n_total++;
      if (observed() !== {e.st, e.cmd}) $display("FAIL %s[%0d]: got %b want %b", e.name, t, observed(), {e.st, e.cmd});
      else n_pass++;
    end
  endtask

  initial begin
    rst                  = 1'b1;
    aif.i_enable         = 1'b1;
    aif.i_tick           = 1'b0;
    aif.i_player_x       = 11'd0;
    aif.i_player_y       = 10'd200;
    aif.i_enemy_x        = 11'd0;
    aif.i_enemy_y        = 10'd200;
    aif.i_enemy_hp       = 2'd3;
    aif.i_goodbullet_x   = 11'd0;
    aif.i_goodbullet_y   = 10'd0;
    aif.i_goodbullet_isE = 1'b0;
    aif.i_badbullet_isE  = 1'b0;
    test_reset();
    test_move();
    test_fire();
    test_evade();
    test_abort();
    test_low_hp();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
